// File: rtl/mem_arb_if.sv
// Bus bundle between the memory arbiter, its two requesters (fetch, D-cache)
// and the memory port. The arbiter takes the slave view.
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_ack_o;
  logic [DATA_W-1:0] i_data_o;
  logic              d_req_i;
  logic              d_write_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_ack_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;
  logic              stall_o;
  logic              err_o;

  modport slave (
    input  i_req_i, i_addr_i, d_req_i, d_write_i, d_addr_i, d_wdata_i,
           mem_ack_i, mem_data_i,
    output i_ack_o, i_data_o, d_ack_o, d_rdata_o, mem_enable_o, mem_write_o,
           mem_addr_o, mem_data_o, stall_o, err_o
  );

  modport master (
    output i_req_i, i_addr_i, d_req_i, d_write_i, d_addr_i, d_wdata_i,
           mem_ack_i, mem_data_i,
    input  i_ack_o, i_data_o, d_ack_o, d_rdata_o, mem_enable_o, mem_write_o,
           mem_addr_o, mem_data_o, stall_o, err_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / D-cache) arbiter for the single memory port, with
// round-robin tie break, per-transfer timeout and pipeline stall generation.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 256,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic     clk,
  input  logic     rst_i,
  mem_arb_if.slave bus
);
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t            state, state_nxt;
  logic              last_d, last_d_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              i_ack, i_ack_nxt, d_ack, d_ack_nxt;
  logic [DATA_W-1:0] i_data, i_data_nxt, d_rdata, d_rdata_nxt;
  logic              en, en_nxt, wr, wr_nxt, err, err_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [DATA_W-1:0] wdata, wdata_nxt;
  logic              grant_d;

  always_comb begin
    state_nxt   = state;
    last_d_nxt  = last_d;
    cnt_nxt     = cnt;
    i_ack_nxt   = 1'b0;
    d_ack_nxt   = 1'b0;
    i_data_nxt  = i_data;
    d_rdata_nxt = d_rdata;
    en_nxt      = en;
    wr_nxt      = wr;
    addr_nxt    = addr;
    wdata_nxt   = wdata;
    err_nxt     = err;
    grant_d     = 1'b0;
    unique case (state)
      IDLE: begin
        // Tie goes to whichever side did not win last time.
        grant_d = bus.d_req_i && (!bus.i_req_i || !last_d);
        if (bus.d_req_i || bus.i_req_i) begin
          en_nxt     = 1'b1;
          cnt_nxt    = '0;
          last_d_nxt = grant_d;
          wr_nxt     = grant_d && bus.d_write_i;
          addr_nxt   = grant_d ? bus.d_addr_i : bus.i_addr_i;
          if (grant_d) wdata_nxt = bus.d_wdata_i;
          state_nxt  = grant_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack_i) begin
          if (state == BUSY_I) begin
            i_ack_nxt  = 1'b1;
            i_data_nxt = bus.mem_data_i;
          end else begin
            d_ack_nxt = 1'b1;
            if (!wr) d_rdata_nxt = bus.mem_data_i;
          end
          en_nxt    = 1'b0;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          // Abort: requester is released with its data left untouched.
          err_nxt   = 1'b1;
          en_nxt    = 1'b0;
          i_ack_nxt = (state == BUSY_I);
          d_ack_nxt = (state == BUSY_D);
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      cnt     <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_data  <= '0;
      d_rdata <= '0;
      en      <= 1'b0;
      wr      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_d  <= last_d_nxt;
      cnt     <= cnt_nxt;
      i_ack   <= i_ack_nxt;
      d_ack   <= d_ack_nxt;
      i_data  <= i_data_nxt;
      d_rdata <= d_rdata_nxt;
      en      <= en_nxt;
      wr      <= wr_nxt;
      addr    <= addr_nxt;
      wdata   <= wdata_nxt;
      err     <= err_nxt;
    end
  end

  assign bus.i_ack_o      = i_ack;
  assign bus.i_data_o     = i_data;
  assign bus.d_ack_o      = d_ack;
  assign bus.d_rdata_o    = d_rdata;
  assign bus.mem_enable_o = en;
  assign bus.mem_write_o  = wr;
  assign bus.mem_addr_o   = addr;
  assign bus.mem_data_o   = wdata;
  assign bus.err_o        = err;
  // Low in DONE so the pipeline advances on the ack cycle.
  assign bus.stall_o = (state == BUSY_I) || (state == BUSY_D) ||
                       ((state == IDLE) && (bus.i_req_i || bus.d_req_i));
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario tasks drive requesters and
// memory; every ack is scored against a queue of expected (side, data).
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_i(rst_i), .bus(bus)
  );

  typedef struct { bit is_d; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, n_iack = 0, n_dack = 0;
  logic [DW-1:0] m_idata, m_drdata;

  // Advance to the next falling edge and score any ack seen there.
  task automatic cycle();
    exp_t e;
    logic [DW-1:0] got;
    @(negedge clk);
    if (bus.i_ack_o || bus.d_ack_o) begin
      checks++;
      if (bus.i_ack_o && bus.d_ack_o) begin
        failures++; $display("FAIL dual_ack i_ack=1 d_ack=1 required at most one");
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack i_ack=%0b d_ack=%0b required none", bus.i_ack_o, bus.d_ack_o);
      end else begin
        e = sb.pop_front();
        got = e.is_d ? bus.d_rdata_o : bus.i_data_o;
        if (e.is_d !== bus.d_ack_o) begin
          failures++; $display("FAIL ack_side got d=%0b required d=%0b", bus.d_ack_o, e.is_d);
        end else if (got !== e.data) begin
          failures++; $display("FAIL ack_data got %h required %h", got, e.data);
        end
      end
      if (bus.i_ack_o) n_iack++;
      if (bus.d_ack_o) n_dack++;
    end
  endtask

  task automatic wait_en(output bit ok, output int n);
    n = 0;
    while (bus.mem_enable_o !== 1'b1 && n < 50) begin cycle(); n++; end
    ok = (bus.mem_enable_o === 1'b1);
    if (!ok) begin checks++; failures++; $display("FAIL enable_wait got 0 required 1 within 50 cycles"); end
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    cycle();
    sb.delete();
    m_idata = '0; m_drdata = '0;
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] l;
    l = {8{32'hC0DE_0100}};
    rst_i = 1'b0; bus.i_req_i = 1'b1; bus.i_addr_i = 32'h100;
    cycle(); cycle();
    checks++;
    if ({bus.i_ack_o, bus.d_ack_o, bus.mem_enable_o, bus.mem_write_o, bus.err_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got %b required 00000",
               {bus.i_ack_o, bus.d_ack_o, bus.mem_enable_o, bus.mem_write_o, bus.err_o});
    end
    checks++;
    if (bus.i_data_o !== '0 || bus.d_rdata_o !== '0) begin
      failures++; $display("FAIL reset_data got i=%h d=%h required 0", bus.i_data_o, bus.d_rdata_o);
    end
    checks++;
    if (bus.mem_addr_o !== '0 || bus.mem_data_o !== '0) begin
      failures++; $display("FAIL reset_membus got a=%h d=%h required 0", bus.mem_addr_o, bus.mem_data_o);
    end
    checks++;
    if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL reset_stall got %b required 1", bus.stall_o); end
    rst_i = 1'b1;
    cycle();
    checks++;
    if (bus.mem_enable_o !== 1'b1 || bus.mem_addr_o !== 32'h100 || bus.mem_write_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_grant got en=%b a=%h w=%b required en=1 a=100 w=0",
               bus.mem_enable_o, bus.mem_addr_o, bus.mem_write_o);
    end
    cycle();
    bus.mem_ack_i = 1'b1; bus.mem_data_i = l; m_idata = l; sb.push_back('{1'b0, l});
    cycle();
    bus.mem_ack_i = 1'b0; bus.i_req_i = 1'b0;
    checks++;
    if (n_iack !== 1) begin failures++; $display("FAIL reset_first_iack got %0d required 1", n_iack); end
    cycle();
  endtask

  task automatic test_d_fill();
    bit ok, bad; int n, d0;
    logic [DW-1:0] l;
    l = {32{8'hAB}}; bad = 1'b0; d0 = n_dack;
    bus.d_req_i = 1'b1; bus.d_write_i = 1'b0; bus.d_addr_i = 32'h2000;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL fill_stall_req got %b required 1", bus.stall_o); end
    wait_en(ok, n);
    checks++;
    if (bus.mem_addr_o !== 32'h2000 || bus.mem_write_o !== 1'b0) begin
      failures++; $display("FAIL fill_grant got a=%h w=%b required a=2000 w=0", bus.mem_addr_o, bus.mem_write_o);
    end
    for (int i = 1; i <= 10; i++) begin
      if (bus.stall_o !== 1'b1 || bus.d_ack_o !== 1'b0) bad = 1'b1;
      if (i < 10) cycle();
    end
    checks++;
    if (bad) begin failures++; $display("FAIL fill_busy got stall/ack wrong required stall=1 ack=0"); end
    bus.mem_ack_i = 1'b1; bus.mem_data_i = l; m_drdata = l; sb.push_back('{1'b1, l});
    cycle();
    bus.mem_ack_i = 1'b0;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.d_ack_o !== 1'b1) begin
      failures++; $display("FAIL fill_done got stall=%b ack=%b required stall=0 ack=1", bus.stall_o, bus.d_ack_o);
    end
    bus.d_req_i = 1'b0;
    cycle();
    checks++;
    if (bus.d_ack_o !== 1'b0 || n_dack - d0 !== 1 || bus.d_rdata_o !== l) begin
      failures++;
      $display("FAIL fill_pulse got ack=%b acks=%0d rdata=%h required ack=0 acks=1 rdata=%h",
               bus.d_ack_o, n_dack - d0, bus.d_rdata_o, l);
    end
  endtask

  task automatic test_tie();
    bit ok, exp_d; int n;
    logic [DW-1:0] w, l;
    w = {8{32'h7777_0001}};
    apply_reset();
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h300;
    bus.d_req_i = 1'b1; bus.d_addr_i = 32'h400; bus.d_write_i = 1'b1; bus.d_wdata_i = w;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      wait_en(ok, n);
      if (!ok) break;
      if (k > 0) begin
        checks++;
        if (n !== 2) begin failures++; $display("FAIL tie_bubble[%0d] got %0d required 2", k, n); end
      end
      checks++;
      if (bus.mem_addr_o !== (exp_d ? 32'h400 : 32'h300) || bus.mem_write_o !== exp_d) begin
        failures++;
        $display("FAIL tie_grant[%0d] got a=%h w=%b required d=%0b", k, bus.mem_addr_o, bus.mem_write_o, exp_d);
      end
      if (exp_d) begin
        checks++;
        if (bus.mem_data_o !== w) begin failures++; $display("FAIL tie_wdata got %h required %h", bus.mem_data_o, w); end
      end
      cycle(); cycle();
      l = {8{32'h1000_0000 + k}};
      bus.mem_ack_i = 1'b1; bus.mem_data_i = l;
      if (exp_d) sb.push_back('{1'b1, m_drdata});
      else begin m_idata = l; sb.push_back('{1'b0, l}); end
      cycle();
      bus.mem_ack_i = 1'b0;
    end
    bus.i_req_i = 1'b0; bus.d_req_i = 1'b0;
    cycle(); cycle();
  endtask

  task automatic test_writeback();
    bit ok, bad; int n;
    logic [DW-1:0] w;
    w = {32{8'h55}}; bad = 1'b0;
    bus.d_req_i = 1'b1; bus.d_write_i = 1'b1; bus.d_wdata_i = w; bus.d_addr_i = 32'h500;
    wait_en(ok, n);
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_write_o !== 1'b1 || bus.mem_data_o !== w || bus.mem_enable_o !== 1'b1 ||
          bus.mem_addr_o !== 32'h500) bad = 1'b1;
      if (i < 4) cycle();
    end
    checks++;
    if (bad) begin failures++; $display("FAIL wb_hold got w=%b d=%h required w=1 d=%h", bus.mem_write_o, bus.mem_data_o, w); end
    bus.mem_ack_i = 1'b1; bus.mem_data_i = {8{32'hDEAD_BEEF}};
    sb.push_back('{1'b1, m_drdata});
    cycle();
    bus.mem_ack_i = 1'b0; bus.d_req_i = 1'b0; bus.d_write_i = 1'b0;
    checks++;
    if (bus.d_rdata_o !== m_drdata) begin
      failures++; $display("FAIL wb_rdata got %h required %h", bus.d_rdata_o, m_drdata);
    end
    cycle();
  endtask

  task automatic test_timeout();
    bit ok; int n, i0;
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h600;
    wait_en(ok, n);
    checks++;
    if (bus.err_o !== 1'b0) begin failures++; $display("FAIL to_err_early got %b required 0", bus.err_o); end
    i0 = n_iack; n = 0;
    sb.push_back('{1'b0, m_idata});
    while (n_iack == i0 && n < 100) begin cycle(); n++; end
    checks++;
    if (n !== TO) begin failures++; $display("FAIL to_cycles got %0d required %0d", n, TO); end
    checks++;
    if (bus.err_o !== 1'b1) begin failures++; $display("FAIL to_err got %b required 1", bus.err_o); end
    bus.i_req_i = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_data_i = {8{32'hBAD0_0000}};
    cycle(); cycle();
    bus.mem_ack_i = 1'b0;
    cycle();
    checks++;
    if (n_iack - i0 !== 1 || bus.mem_enable_o !== 1'b0 || bus.err_o !== 1'b1) begin
      failures++;
      $display("FAIL to_spurious got acks=%0d en=%b err=%b required acks=1 en=0 err=1",
               n_iack - i0, bus.mem_enable_o, bus.err_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int n, d0;
    d0 = n_dack;
    bus.d_req_i = 1'b1; bus.d_write_i = 1'b0; bus.d_addr_i = 32'h700;
    wait_en(ok, n);
    cycle(); cycle();
    rst_i = 1'b0; bus.d_req_i = 1'b0;
    cycle();
    sb.delete(); m_idata = '0; m_drdata = '0;
    rst_i = 1'b1; bus.mem_ack_i = 1'b1; bus.mem_data_i = {8{32'hFEED_0700}};
    cycle();
    bus.mem_ack_i = 1'b0;
    cycle();
    checks++;
    if (n_dack !== d0 || bus.mem_enable_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got acks=%0d en=%b stall=%b required acks=0 en=0 stall=0",
               n_dack - d0, bus.mem_enable_o, bus.stall_o);
    end
    checks++;
    if (bus.err_o !== 1'b0 || bus.d_rdata_o !== '0) begin
      failures++; $display("FAIL mid_reset_clear got err=%b rdata=%h required 0", bus.err_o, bus.d_rdata_o);
    end
  endtask

  initial begin
    rst_i = 1'b0;
    bus.i_req_i = 1'b0; bus.i_addr_i = '0;
    bus.d_req_i = 1'b0; bus.d_write_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
    bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
    m_idata = '0; m_drdata = '0;
    test_reset();
    test_d_fill();
    test_tie();
    test_writeback();
    test_timeout();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL sb_drain got %0d pending required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-chip data-memory port between the instruction-fetch requester and the data-cache miss/write-back requester.
- Sequences each transfer with a four-state FSM and returns read data to the granted side.
- Drives the pipeline-wide memory-stall signal that freezes the IF/ID and downstream pipeline registers while a transfer is outstanding.
- Sits between the IF-stage fetch logic, the D-cache controller and the data memory model.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 256, memory line width (one cache line per transfer)
- TIMEOUT_CYC, 64, cycles a granted transfer may wait for mem_ack_i before being aborted

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-low reset; sampled only at posedge clk
- i_req_i  input  1  fetch read request; held high until i_ack_o
- i_addr_i  input  ADDR_W  fetch line address
- i_ack_o  output  1  one-cycle pulse: i_data_o valid
- i_data_o  output  DATA_W  fetched line
- d_req_i  input  1  data request; held high until d_ack_o
- d_write_i  input  1  1 = write-back, 0 = line fill
- d_addr_i  input  ADDR_W  data line address
- d_wdata_i  input  DATA_W  write-back line
- d_ack_o  output  1  one-cycle pulse: transfer done, d_rdata_o valid on reads
- d_rdata_o  output  DATA_W  filled line
- mem_enable_o  output  1  memory request, level-held until ack
- mem_write_o  output  1  memory write select
- mem_addr_o  output  ADDR_W  memory address
- mem_data_o  output  DATA_W  memory write data
- mem_ack_i  input  1  memory completion pulse
- mem_data_i  input  DATA_W  memory read data, valid with mem_ack_i
- stall_o  output  1  pipeline memory stall (combinational)
- err_o  output  1  sticky timeout flag

Behaviour:
- Reset (rst_i==0 at posedge):
  - state=IDLE; last_grant=I.
  - All registered outputs 0: i_ack_o, d_ack_o, i_data_o, d_rdata_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, err_o; timeout counter 0.
  - Reset mid-transfer aborts it immediately; a late mem_ack_i arriving afterwards is ignored.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - Only d_req: grant D.
  - Only i_req: grant I.
  - Both: grant the side not in last_grant, so D wins the first tie after reset.
  - On grant, at the same edge: latch addr, write and wdata into the mem_* outputs; set mem_enable_o=1; update last_grant; clear the counter; go to BUSY_x.
  - mem_write_o is 1 only for a D write; an I grant forces 0.
- BUSY_x:
  - mem_* outputs are held stable; the counter increments each cycle.
  - On mem_ack_i=1:
    - Capture mem_data_i into i_data_o (BUSY_I) or d_rdata_o (BUSY_D).
    - Data is captured on reads only; d_rdata_o is unchanged on writes.
    - Pulse the matching ack for exactly 1 cycle; mem_enable_o=0; go to DONE.
  - If the counter reaches TIMEOUT_CYC-1 with no ack: set err_o; mem_enable_o=0; pulse the matching ack with data unchanged; go to DONE.
- DONE:
  - Lasts one cycle; no grant is issued, so a req still high in this cycle is not re-granted.
  - Next state is IDLE.
  - Requesters must drop or renew req by the following edge.
- stall_o = (state==BUSY_I or state==BUSY_D) or (state==IDLE and (i_req_i or d_req_i)).
  - stall_o is 0 in DONE, so the pipeline advances exactly on the ack cycle.
- Latency: req seen in IDLE at cycle 0 -> mem_enable_o high in cycle 1 -> mem_ack_i in cycle k -> ack_o and data in cycle k+1 -> IDLE in cycle k+2.
- Request dropped while BUSY: the transfer still completes and the ack still pulses.
- mem_ack_i in IDLE or DONE: ignored, and no output changes.
- err_o clears only on reset.
- i_ack_o and d_ack_o are never high in the same cycle.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with i_req_i=1 -> all outputs 0, stall_o=1, no mem_enable_o. Release reset -> mem_enable_o=1 next cycle with mem_addr_o=i_addr_i=0x100.
- Single D fill: d_req_i=1, d_write_i=0, addr 0x2000; memory acks 10 cycles after enable with data 0xAB..AB -> d_ack_o pulses once, d_rdata_o=0xAB..AB. stall_o=1 from the req cycle through the ack cycle, then 0 in DONE.
- Tie fairness: i_req and d_req held high continuously, memory acking after 3 cycles -> grant order D, I, D, I. One DONE bubble between transfers; mem_write_o matches d_write_i only on D grants.
- D write-back: d_write_i=1, wdata=0x55..55 -> mem_write_o=1, mem_data_o=0x55..55 for the whole BUSY period. d_ack_o pulses; d_rdata_o unchanged.
- Timeout: grant I and never ack -> after TIMEOUT_CYC=64 BUSY cycles, err_o=1, i_ack_o pulses, state goes to IDLE. A later spurious mem_ack_i causes no ack.
- Reset mid-transfer: rst_i=0 during BUSY_D, then mem_ack_i arrives -> no d_ack_o, state IDLE, mem_enable_o=0.
